// File: rtl/free_list_pkg.sv
// Shared definitions for the physical-register free list: default configuration,
// pointer and tag types.
package free_list_pkg;

  localparam int DEPTH_DEF = 64;
  localparam int ARCH_DEF  = 32;
  localparam int N_DEF     = 3;

  localparam int FL_SZ  = DEPTH_DEF - ARCH_DEF;
  localparam int FL_LOG = $clog2(FL_SZ);

  // Head/tail pointer: the MSB is the wrap bit, the low FL_LOG bits index entries.
  typedef logic [FL_LOG:0]                FL_PTR;
  typedef logic [$clog2(DEPTH_DEF)-1:0]   PHYS_REG_IDX;

endpackage

// File: rtl/lane_compact.sv
// N-lane exclusive prefix popcount: each valid lane gets its packed write
// offset, and the total count of valid lanes is returned alongside.
module lane_compact #(
  parameter  int N  = 3,
  localparam int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]         valid,
  output logic [N-1:0][CW-1:0] offset,
  output logic [CW-1:0]        total
);

  logic [CW-1:0] acc;

  always_comb begin
    acc    = '0;
    offset = '0;
    for (int i = 0; i < N; i++) begin
      offset[i] = acc;
      acc       = acc + CW'(valid[i]);
    end
    total = acc;
  end

endmodule

// File: rtl/free_list.sv
// Circular free list of physical register tags: dispatch takes tags at head,
// retirement returns t_old tags at tail, and a mispredict rewinds head.
module free_list
  import free_list_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEF,
  parameter  int ARCH  = ARCH_DEF,
  parameter  int N     = N_DEF,
  localparam int CAP   = DEPTH - ARCH,
  localparam int LOG   = $clog2(CAP),
  localparam int IDX_W = $clog2(DEPTH),
  localparam int CW    = $clog2(N + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [CW-1:0]           rd_num,
  input  logic [N-1:0]            ret_valid,
  input  logic [N-1:0][IDX_W-1:0] ret_t_old,
  input  logic                    br_en,
  input  logic [LOG:0]            br_head,
  output logic [N-1:0][IDX_W-1:0] alloc_regs,
  output logic [CW-1:0]           num_avail,
  output logic [LOG:0]            num_free,
  output logic [LOG:0]            out_head
);

  // Contract: dispatch may take rd_num <= num_avail tags this cycle, reading them
  // from alloc_regs combinationally; retire lanes with ret_valid set are always
  // accepted (no backpressure), and the caller guarantees the list never overfills.

  logic [IDX_W-1:0]       entries [CAP];
  logic [LOG:0]           head;
  logic [LOG:0]           tail;
  logic [LOG:0]           head_next;
  logic [N-1:0][CW-1:0]   ret_off;
  logic [CW-1:0]          ret_cnt;
  logic [N-1:0][LOG-1:0]  wr_idx;
  logic [LOG:0]           br_dist;

  lane_compact #(.N(N)) u_compact (
    .valid  (ret_valid),
    .offset (ret_off),
    .total  (ret_cnt)
  );

  assign num_free = tail - head;
  assign out_head = head;

  always_comb begin
    num_avail = num_free[CW-1:0];
    if (num_free >= (LOG+1)'(N)) num_avail = CW'(N);
  end

  always_comb begin
    alloc_regs = '0;
    wr_idx     = '0;
    for (int j = 0; j < N; j++) begin
      alloc_regs[j] = entries[head[LOG-1:0] + LOG'(j)];
      wr_idx[j]     = tail[LOG-1:0] + LOG'(ret_off[j]);
    end
  end

  // A restore overrides dispatch: the pipeline is stalled on a mispredict cycle.
  always_comb begin
    head_next = head + (LOG+1)'(rd_num);
    if (br_en) head_next = br_head;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CAP; i++) entries[i] <= IDX_W'(ARCH + i);
      head <= '0;
      tail <= {1'b1, {LOG{1'b0}}};
    end else begin
      for (int i = 0; i < N; i++) begin
        if (ret_valid[i]) entries[wr_idx[i]] <= ret_t_old[i];
      end
      head <= head_next;
      tail <= tail + (LOG+1)'(ret_cnt);
    end
  end

  assign br_dist = head - br_head;

  a_rd_le_avail: assert property (@(posedge clock) disable iff (!reset)
    br_en || (rd_num <= num_avail));
  a_no_overfill: assert property (@(posedge clock) disable iff (!reset)
    (({1'b0, num_free}) + (LOG+2)'(ret_cnt)) <= (LOG+2)'(CAP));
  a_br_window: assert property (@(posedge clock) disable iff (!reset)
    !br_en || (br_dist <= (LOG+1)'(CAP)));

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list (DEPTH=64, ARCH=32, N=3): reset, allocate,
// drain/free, wrap with a tag FIFO scoreboard, mispredict restore, async reset.
module tb_free_list;
  import free_list_pkg::*;

  localparam int N     = 3;
  localparam int IDX_W = 6;
  localparam int LOG   = 5;
  localparam int CW    = 2;

  logic                    clock = 1'b0;
  logic                    reset;
  logic [CW-1:0]           rd_num;
  logic [N-1:0]            ret_valid;
  logic [N-1:0][IDX_W-1:0] ret_t_old;
  logic                    br_en;
  logic [LOG:0]            br_head;
  logic [N-1:0][IDX_W-1:0] alloc_regs;
  logic [CW-1:0]           num_avail;
  logic [LOG:0]            num_free;
  logic [LOG:0]            out_head;

  int total = 0;
  int bad   = 0;

  logic [IDX_W-1:0] exp_q[$];
  logic [IDX_W-1:0] prev [N];
  logic [IDX_W-1:0] cur  [N];
  int               exp_head;

  free_list #(.DEPTH(64), .ARCH(32), .N(N)) dut (
    .clock      (clock),
    .reset      (reset),
    .rd_num     (rd_num),
    .ret_valid  (ret_valid),
    .ret_t_old  (ret_t_old),
    .br_en      (br_en),
    .br_head    (br_head),
    .alloc_regs (alloc_regs),
    .num_avail  (num_avail),
    .num_free   (num_free),
    .out_head   (out_head)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic chk_alloc(input string tag, input int a0, input int a1, input int a2);
    chk({tag, "_lane0"}, 32'(alloc_regs[0]), 32'(a0));
    chk({tag, "_lane1"}, 32'(alloc_regs[1]), 32'(a1));
    chk({tag, "_lane2"}, 32'(alloc_regs[2]), 32'(a2));
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    rd_num    = '0;
    ret_valid = '0;
    ret_t_old = '0;
    br_en     = 1'b0;
    br_head   = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;

    // 1. reset
    step();
    chk("rst_free_held", 32'(num_free), 32);
    reset = 1'b1;
    step();
    chk_alloc("rst_alloc", 32, 33, 34);
    chk("rst_avail", 32'(num_avail), 3);
    chk("rst_free", 32'(num_free), 32);
    chk("rst_head", 32'(out_head), 0);

    // 2. single allocate of 2
    rd_num = 2'd2;
    step();
    rd_num = '0;
    chk_alloc("alloc2", 34, 35, 36);
    chk("alloc2_free", 32'(num_free), 30);
    chk("alloc2_head", 32'(out_head), 2);
    chk("alloc2_avail", 32'(num_avail), 3);

    // 3. drain the remaining 30, then sparse free of lanes 0 and 2
    for (int i = 0; i < 10; i++) begin
      rd_num = 2'd3;
      step();
    end
    rd_num = '0;
    chk("drain_free", 32'(num_free), 0);
    chk("drain_avail", 32'(num_avail), 0);
    chk("drain_head", 32'(out_head), 32);
    ret_valid    = 3'b101;
    ret_t_old[0] = 6'd5;
    ret_t_old[1] = 6'd9;
    ret_t_old[2] = 6'd7;
    step();
    idle_inputs();
    chk("sparse_free", 32'(num_free), 2);
    chk("sparse_lane0", 32'(alloc_regs[0]), 5);
    chk("sparse_lane1", 32'(alloc_regs[1]), 7);
    chk("sparse_avail", 32'(num_avail), 2);

    // 4. wrap: steady allocate 3 / free 3 against a FIFO of expected tags
    do_reset();
    exp_q.delete();
    for (int i = 32; i < 64; i++) exp_q.push_back(IDX_W'(i));
    exp_head = 0;
    for (int k = 0; k < 200; k++) begin
      chk("wrap_free", 32'(num_free), 32'(exp_q.size()));
      chk("wrap_head", 32'(out_head), 32'(exp_head));
      for (int j = 0; j < N; j++) chk("wrap_tag", 32'(alloc_regs[j]), 32'(exp_q[j]));
      rd_num = 2'd3;
      if (k > 0) begin
        ret_valid    = 3'b111;
        ret_t_old[0] = prev[2];
        ret_t_old[1] = prev[1];
        ret_t_old[2] = prev[0];
      end else begin
        ret_valid = '0;
      end
      for (int j = 0; j < N; j++) cur[j] = exp_q.pop_front();
      if (k > 0) begin
        exp_q.push_back(prev[2]);
        exp_q.push_back(prev[1]);
        exp_q.push_back(prev[0]);
      end
      for (int j = 0; j < N; j++) prev[j] = cur[j];
      exp_head = (exp_head + 3) % 64;
      step();
    end
    idle_inputs();
    chk("wrap_end_free", 32'(num_free), 29);
    chk("wrap_end_head", 32'(out_head), 32'(exp_head));
    chk("wrap_end_tag", 32'(alloc_regs[0]), 32'(exp_q[0]));

    // 5. mispredict restore with a same-cycle free
    do_reset();
    rd_num = 2'd3;
    step();
    rd_num = 2'd1;
    step();
    rd_num = '0;
    chk("ckpt_head", 32'(out_head), 4);
    chk_alloc("ckpt_alloc", 36, 37, 38);
    rd_num = 2'd3;
    step();
    step();
    rd_num = '0;
    chk("spec_free", 32'(num_free), 22);
    chk("spec_head", 32'(out_head), 10);
    br_en        = 1'b1;
    br_head      = 6'd4;
    rd_num       = 2'd3;
    ret_valid    = 3'b001;
    ret_t_old[0] = 6'd2;
    step();
    idle_inputs();
    chk("br_head", 32'(out_head), 4);
    chk("br_free", 32'(num_free), 29);
    chk_alloc("br_alloc", 36, 37, 38);

    // 6. async reset between edges while num_free = 10
    for (int i = 0; i < 6; i++) begin
      rd_num = 2'd3;
      step();
    end
    rd_num = 2'd1;
    step();
    rd_num = '0;
    chk("pre_arst_free", 32'(num_free), 10);
    chk("pre_arst_head", 32'(out_head), 23);
    rd_num       = 2'd3;
    ret_valid    = 3'b111;
    ret_t_old[0] = 6'd11;
    ret_t_old[1] = 6'd12;
    ret_t_old[2] = 6'd13;
    #3;
    reset = 1'b0;
    #1;
    chk("arst_free", 32'(num_free), 32);
    chk("arst_avail", 32'(num_avail), 3);
    chk("arst_head", 32'(out_head), 0);
    chk_alloc("arst_alloc", 32, 33, 34);
    step();
    idle_inputs();
    step();
    reset = 1'b1;
    step();
    chk("post_arst_free", 32'(num_free), 32);
    chk("post_arst_head", 32'(out_head), 0);
    chk_alloc("post_arst_alloc", 32, 33, 34);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
